// File: rtl/bin2bcd_seg_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) with
// registered active-low 7-segment outputs, leading-zero blanking and overflow.
module bin2bcd_seg_seq #(
    parameter int BIN_W    = 9,
    parameter int DIGITS   = 3,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   seg
);

    localparam int CNT_W = $clog2(BIN_W + 1);

    localparam logic [6:0] SEG_ZERO  = 7'b0000001;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [BIN_W-1:0]     bin_sr;
    logic [4*DIGITS-1:0]  scratch;
    logic                 ovf_sticky;
    logic [4*DIGITS-1:0]  adj;
    logic [7*DIGITS-1:0]  seg_next;
    logic                 lead;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b0000001;
            4'd1:    return 7'b1001111;
            4'd2:    return 7'b0010010;
            4'd3:    return 7'b0000110;
            4'd4:    return 7'b1001100;
            4'd5:    return 7'b0100100;
            4'd6:    return 7'b0100000;
            4'd7:    return 7'b0001111;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0000100;
            default: return SEG_BLANK;
        endcase
    endfunction

    // Saturated result shown when the value does not fit in DIGITS digits.
    function automatic logic [4*DIGITS-1:0] sat_bcd();
        return {DIGITS{4'h9}};
    endfunction

    function automatic logic [7*DIGITS-1:0] sat_seg();
        return {DIGITS{SEG_DASH}};
    endfunction

    function automatic logic [7*DIGITS-1:0] reset_seg();
        logic [7*DIGITS-1:0] s;
        s = '0;
        for (int k = 0; k < DIGITS; k++)
            s[7*k +: 7] = (k == 0 || !BLANK_LZ) ? SEG_ZERO : SEG_BLANK;
        return s;
    endfunction

    // Add-3 correction applied to every digit before each shift.
    always_comb begin
        adj = scratch;
        for (int k = 0; k < DIGITS; k++) begin
            if (scratch[4*k +: 4] >= 4'd5)
                adj[4*k +: 4] = scratch[4*k +: 4] + 4'd3;
        end
    end

    // Blanking walks from the most significant digit down; digit 0 always shows.
    always_comb begin
        seg_next = '0;
        lead     = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            if (scratch[4*k +: 4] != 4'd0)
                lead = 1'b0;
            if (BLANK_LZ && lead && k != 0)
                seg_next[7*k +: 7] = SEG_BLANK;
            else
                seg_next[7*k +: 7] = seg7(scratch[4*k +: 4]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
            bcd      <= '0;
            seg      <= reset_seg();
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt   <= CNT_W'(BIN_W);
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1))
                        state <= LOAD;
                end
                LOAD: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                    if (ovf_sticky) begin
                        overflow <= 1'b1;
                        bcd      <= sat_bcd();
                        seg      <= sat_seg();
                    end else begin
                        overflow <= 1'b0;
                        bcd      <= scratch;
                        seg      <= seg_next;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath: the bit shifted out of the top digit marks the value as too large.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            bin_sr     <= bin;
            scratch    <= '0;
            ovf_sticky <= 1'b0;
        end else if (state == SHIFT) begin
            scratch    <= {adj[4*DIGITS-2:0], bin_sr[BIN_W-1]};
            bin_sr     <= bin_sr << 1;
            ovf_sticky <= ovf_sticky | adj[4*DIGITS-1];
        end
    end

endmodule

// File: doc/bin2bcd_seg_seq.md
Name: bin2bcd_seg_seq

Overview:
- Sequential, parametrised binary-to-decimal converter with an integrated 7-segment encoder.
- Converts a BIN_W-bit unsigned value into DIGITS BCD digits using iterative shift-add-3 (double dabble), one bit per clock, under a start/busy/done handshake.
- Drives DIGITS active-low 7-segment displays (HEX0 = units upward), with optional leading-zero blanking and an overflow indication.
- Replaces the per-digit combinational divide/modulo display path on switch-driven boards.

Parameters:
- BIN_W, 9, width of the binary input (1..32).
- DIGITS, 3, number of decimal digits and displays driven (1..10).
- BLANK_LZ, 1, 1 = blank leading zero digits; digit 0 is always shown. 0 = show all digits.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  conversion request; sampled only in IDLE.
- bin  input  BIN_W  unsigned binary value; captured on the accepted start cycle.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when new results are valid.
- overflow  output  1  registered; 1 when the last captured value is >= 10^DIGITS.
- bcd  output  4*DIGITS  registered BCD result; digit k is bcd[4k+3:4k].
- seg  output  7*DIGITS  registered active-low segments; digit k is seg[7k+6:7k], with bit 7k+6 = a down to bit 7k = g.

Behaviour:
- Reset (synchronous, rst=1 at the clock edge):
  - FSM goes to IDLE; busy=0, done=0, overflow=0, bcd=0.
  - seg shows value 0: digit 0 = 0000001; higher digits = 1111111 if BLANK_LZ=1, else 0000001.
  - Reset mid-conversion aborts the conversion and leaves no partial result.
- FSM states: IDLE, SHIFT, LOAD.
  - IDLE: when start=1, capture bin into the shift register, clear the BCD scratch, clear the overflow scratch, load bit counter = BIN_W, go to SHIFT. busy rises on the next cycle.
  - SHIFT (one cycle per bit, BIN_W cycles):
    - Add 3 to every scratch digit that is >= 5.
    - Shift {scratch, binary} left by 1.
    - Any 1 shifted out of the top digit sets the sticky overflow scratch.
    - Decrement the counter; after the last bit, go to LOAD.
  - LOAD (1 cycle):
    - Copy results into bcd, seg and overflow; pulse done=1; busy=0 from the next cycle.
    - Return to IDLE.
- Latency: start accepted at edge N -> done=1 during cycle N+BIN_W+1. Outputs are stable from that cycle until the next LOAD.
- busy=1 in SHIFT and LOAD.
- start asserted while busy is ignored (not queued). start held high continuously re-converts back-to-back, with 1 IDLE cycle between conversions.
- Overflow:
  - bcd = all digits 9.
  - Every digit shows a dash, 1111110, regardless of BLANK_LZ.
  - overflow=1.
- Segment codes (a..g, active-low):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - blank=1111111
- Leading-zero blanking (BLANK_LZ=1): digit k>0 is blanked iff digit k and all higher digits are 0. Interior zeros are shown.
- Width rules:
  - Scratch register is 4*DIGITS bits plus the sticky overflow bit.
  - No truncation warnings: bin is zero-extended internally.
  - DIGITS large enough for BIN_W never asserts overflow.

Test Plan:
- Defaults, bin=0, start pulse -> done exactly 10 cycles after the start edge; bcd=12'h000; seg digits (2,1,0)=1111111,1111111,0000001; overflow=0.
- Defaults, bin=9'd511 -> bcd=12'h511; seg = 0100100, 1001111, 1001111; busy high for 10 cycles; done high for exactly 1 cycle.
- Defaults, bin=9'd105 -> bcd=12'h105; digit 1 shows 0000001 (interior zero not blanked). Repeat with BLANK_LZ=0 and bin=7 -> digits 0000001, 0000001, 0001111.
- DIGITS=2, bin=9'd100 -> overflow=1, bcd=8'h99, all segs 1111110. Then bin=99 -> overflow=0, bcd=8'h99, normal digits.
- Defaults, start bin=300 and pulse start again with bin=7 on the 3rd busy cycle -> second start ignored; result 300; a new start after done converts 7 correctly.
- Defaults, assert rst on the 5th SHIFT cycle -> next cycle busy=0, done never pulses, outputs at reset values; a subsequent conversion of bin=42 gives bcd=12'h042.
